// File: rtl/alu_result_collector.sv
// Downstream buffer for the 12-bit ALU: captures each valid result into a small show-ahead FIFO,
// hands it to the consumer over valid/ready, and reports drops plus a saturating overflow count.
module alu_result_collector #(
    parameter int DATA_W = 12,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int OCC_W = PTR_W + 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_overflow,
    input  logic              i_ready,
    input  logic              i_clr_cnt,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic              o_overflow,
    output logic              o_full,
    output logic [OCC_W-1:0]  o_count,
    output logic              o_drop,
    output logic [CNT_W-1:0]  o_ovf_cnt
);

    // Handshake: a head entry transfers on any rising edge where o_valid && i_ready are both high;
    // o_valid stays high until that transfer (or reset), and the head is stable while it waits.

    logic [DATA_W:0]    mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   rd_nxt;
    logic [OCC_W-1:0]   count;
    logic [OCC_W-1:0]   count_nxt;
    logic [DATA_W:0]    head;
    logic [DATA_W:0]    head_nxt;
    logic               full;
    logic               push;
    logic               pop;

    assign full    = (count == OCC_W'(DEPTH));
    assign o_valid = (count != '0);
    assign pop     = o_valid && i_ready;
    assign push    = i_valid && (!full || pop);
    assign rd_nxt  = pop ? rd_ptr + 1'b1 : rd_ptr;

    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    // The head is a register so it reads 0 after reset without clearing the storage array;
    // when the entry being written is the next head, take it from the input directly.
    always_comb begin
        head_nxt = head;
        if (push && (wr_ptr == rd_nxt)) begin
            head_nxt = {i_overflow, i_data};
        end else if (count_nxt != '0) begin
            head_nxt = mem[rd_nxt];
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst && push) begin
            mem[wr_ptr] <= {i_overflow, i_data};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            head      <= '0;
            o_drop    <= 1'b0;
            o_ovf_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            rd_ptr <= rd_nxt;
            count  <= count_nxt;
            head   <= head_nxt;
            o_drop <= i_valid && full && !pop;
            // Overflows are counted whether or not the result found room in the buffer.
            if (i_clr_cnt) begin
                o_ovf_cnt <= '0;
            end else if (i_valid && i_overflow && (o_ovf_cnt != '1)) begin
                o_ovf_cnt <= o_ovf_cnt + 1'b1;
            end
        end
    end

    assign o_data     = head[DATA_W-1:0];
    assign o_overflow = head[DATA_W];
    assign o_full     = full;
    assign o_count    = count;

endmodule

// File: tb/tb_alu_result_collector.sv
// Randomized and directed bench for alu_result_collector: a queue-based reference FIFO predicts
// every output; a negedge monitor compares and pops delivered heads. A CNT_W=2 copy checks saturation.
module tb_alu_result_collector;

    localparam int DATA_W = 12;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 8;
    localparam int OCC_W  = $clog2(DEPTH) + 1;

    logic              i_clk;
    logic              i_rst;
    logic              i_valid;
    logic [DATA_W-1:0] i_data;
    logic              i_overflow;
    logic              i_ready;
    logic              i_clr_cnt;

    logic              o_valid,   o_valid2;
    logic [DATA_W-1:0] o_data,    o_data2;
    logic              o_overflow, o_overflow2;
    logic              o_full,    o_full2;
    logic [OCC_W-1:0]  o_count,   o_count2;
    logic              o_drop,    o_drop2;
    logic [CNT_W-1:0]  o_ovf_cnt;
    logic [1:0]        o_ovf_cnt2;

    alu_result_collector #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_data(i_data),
        .i_overflow(i_overflow), .i_ready(i_ready), .i_clr_cnt(i_clr_cnt),
        .o_valid(o_valid), .o_data(o_data), .o_overflow(o_overflow), .o_full(o_full),
        .o_count(o_count), .o_drop(o_drop), .o_ovf_cnt(o_ovf_cnt)
    );

    alu_result_collector #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(2)) dut2 (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_data(i_data),
        .i_overflow(i_overflow), .i_ready(i_ready), .i_clr_cnt(i_clr_cnt),
        .o_valid(o_valid2), .o_data(o_data2), .o_overflow(o_overflow2), .o_full(o_full2),
        .o_count(o_count2), .o_drop(o_drop2), .o_ovf_cnt(o_ovf_cnt2)
    );

    // ---------------- clock ----------------
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // ---------------- scoreboard state ----------------
    logic [DATA_W:0] exp_q[$];
    int  checks  = 0;
    int  errors  = 0;
    bit  mon_en  = 1'b0;
    bit  pend_pop = 1'b0;
    bit  exp_drop = 1'b0;
    int  exp_ovf  = 0;
    int  exp_ovf2 = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the buffer is just a bounded queue; the monitor has already removed
    // the head if a transfer is due on this edge.
    always @(posedge i_clk) begin
        if (i_rst) begin
            exp_q.delete();
            pend_pop = 1'b0;
            exp_drop = 1'b0;
            exp_ovf  = 0;
            exp_ovf2 = 0;
        end else begin
            exp_drop = i_valid && (exp_q.size() == DEPTH) && !pend_pop;
            if (i_valid && !exp_drop) exp_q.push_back({i_overflow, i_data});
            pend_pop = 1'b0;
            if (i_clr_cnt) begin
                exp_ovf  = 0;
                exp_ovf2 = 0;
            end else if (i_valid && i_overflow) begin
                if (exp_ovf  < 255) exp_ovf++;
                if (exp_ovf2 < 3)   exp_ovf2++;
            end
        end
    end

    // Monitor: compare every output mid-cycle, pop the head when the consumer takes it.
    always @(negedge i_clk) begin
        if (mon_en) begin
            chk("o_valid",    int'(o_valid),    int'(exp_q.size() != 0));
            chk("o_count",    int'(o_count),    exp_q.size());
            chk("o_full",     int'(o_full),     int'(exp_q.size() == DEPTH));
            chk("o_drop",     int'(o_drop),     int'(exp_drop));
            chk("o_ovf_cnt",  int'(o_ovf_cnt),  exp_ovf);
            chk("o_ovf_cnt2", int'(o_ovf_cnt2), exp_ovf2);
            chk("o_count2",   int'(o_count2),   exp_q.size());
            chk("o_drop2",    int'(o_drop2),    int'(exp_drop));
            chk("o_valid2",   int'(o_valid2) + int'(o_full2), int'(exp_q.size() != 0) + int'(exp_q.size() == DEPTH));
            if (exp_q.size() != 0) begin
                chk("o_data",      int'(o_data),      int'(exp_q[0][DATA_W-1:0]));
                chk("o_overflow",  int'(o_overflow),  int'(exp_q[0][DATA_W]));
                chk("o_data2",     int'(o_data2),     int'(exp_q[0][DATA_W-1:0]));
                chk("o_overflow2", int'(o_overflow2), int'(exp_q[0][DATA_W]));
                if (i_ready && !i_rst) begin
                    void'(exp_q.pop_front());
                    pend_pop = 1'b1;
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic cycle(input bit v, input int d, input bit ovf, input bit rdy,
                         input bit clr = 1'b0, input bit rst = 1'b0);
        i_valid    = v;
        i_data     = DATA_W'(d);
        i_overflow = ovf;
        i_ready    = rdy;
        i_clr_cnt  = clr;
        i_rst      = rst;
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int k = 0; k < n; k++) cycle(1'b0, 0, 1'b0, rdy);
    endtask

    initial begin
        i_rst = 1'b1; i_valid = 1'b0; i_data = '0; i_overflow = 1'b0;
        i_ready = 1'b0; i_clr_cnt = 1'b0;
        cycle(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 12'h123, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("rst_o_data", int'(o_data), 0);
        chk("rst_o_overflow", int'(o_overflow), 0);
        chk("rst_o_ovf_cnt", int'(o_ovf_cnt), 0);
        i_rst = 1'b0;
        mon_en = 1'b1;

        // single result held until accepted
        cycle(1'b1, 12'h7FF, 1'b0, 1'b0);
        chk("single_data", int'(o_data), 12'h7FF);
        chk("single_count", int'(o_count), 1);
        idle(2, 1'b0);
        chk("single_hold", int'(o_data), 12'h7FF);
        cycle(1'b0, 0, 1'b0, 1'b1);
        chk("single_gone", int'(o_valid), 0);

        // fill and drop
        for (int k = 1; k <= 5; k++) cycle(1'b1, k, 1'b0, 1'b0);
        chk("fill_full", int'(o_full), 1);
        chk("fill_drop", int'(o_drop), 1);
        idle(1, 1'b0);
        chk("drop_one_pulse", int'(o_drop), 0);
        idle(5, 1'b1);

        // full with simultaneous pop
        for (int k = 1; k <= 4; k++) cycle(1'b1, k, 1'b0, 1'b0);
        cycle(1'b1, 9, 1'b0, 1'b1);
        chk("fullpop_count", int'(o_count), 4);
        chk("fullpop_head", int'(o_data), 2);
        cycle(1'b0, 0, 1'b0, 1'b0);
        chk("fullpop_nodrop", int'(o_drop), 0);
        idle(5, 1'b1);

        // overflow counting, one overflow dropped while full
        cycle(1'b0, 0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 12'hA, 1'b1, 1'b0);
        cycle(1'b1, 12'hB, 1'b0, 1'b0);
        cycle(1'b1, 12'hC, 1'b1, 1'b0);
        cycle(1'b1, 12'hD, 1'b0, 1'b0);
        cycle(1'b1, 12'hE, 1'b1, 1'b0);
        chk("ovf_cnt3", int'(o_ovf_cnt), 3);
        idle(5, 1'b1);
        for (int k = 0; k < 5; k++) cycle(1'b1, 12'h800 + k, 1'b1, 1'b1);
        chk("ovf_sat2", int'(o_ovf_cnt2), 3);
        cycle(1'b1, 12'hF00, 1'b1, 1'b1, 1'b1);
        chk("ovf_clr_wins", int'(o_ovf_cnt), 0);
        idle(2, 1'b1);

        // streaming
        for (int k = 0; k < 20; k++) begin
            cycle(1'b1, int'($urandom_range(0, 4095)), 1'($urandom_range(0, 1)), 1'b1);
            chk("stream_occ", int'(o_count), 1);
        end
        idle(2, 1'b1);

        // reset mid-operation
        for (int k = 0; k < 3; k++) cycle(1'b1, 12'h300 + k, 1'b1, 1'b0);
        cycle(1'b1, 12'h3FF, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("mid_rst_valid", int'(o_valid), 0);
        chk("mid_rst_data", int'(o_data), 0);
        chk("mid_rst_ovf", int'(o_overflow), 0);
        chk("mid_rst_cnt", int'(o_ovf_cnt), 0);
        idle(2, 1'b1);

        // random traffic
        for (int k = 0; k < 400; k++) begin
            cycle(1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 4095)),
                  1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 31) == 0), 1'($urandom_range(0, 99) == 0));
        end

        idle(DEPTH + 2, 1'b1);
        chk("final_empty", int'(o_count), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_result_collector.md
# alu_result_collector

Downstream stage of the 12-bit ALU: captures each registered ALU result (data plus overflow flag) in the cycle its valid is high, buffers it in a small show-ahead FIFO, and presents it to the consumer over a valid/ready handshake. The ALU has no backpressure, so the block also reports results dropped on a full buffer and keeps a saturating count of overflowing results for status readout.

## Interface
- DATA_W, 12, result width; equals ALU data width.
- DEPTH, 4, FIFO entries; power of two, at least 2.
- CNT_W, 8, overflow counter width.

- i_clk  in  1  single clock; all logic on rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_valid  in  1  ALU result valid (ALU o_valid).
- i_data  in  DATA_W  ALU result (ALU o_data).
- i_overflow  in  1  ALU overflow flag (ALU o_overflow).
- i_ready  in  1  consumer accepts head entry this cycle.
- i_clr_cnt  in  1  synchronous clear of o_ovf_cnt.
- o_valid  out  1  FIFO non-empty; head entry on o_data/o_overflow.
- o_data  out  DATA_W  head entry data.
- o_overflow  out  1  head entry overflow flag.
- o_full  out  1  occupancy == DEPTH.
- o_count  out  log2(DEPTH)+1  current occupancy, 0..DEPTH.
- o_drop  out  1  one-cycle pulse: a result was discarded.
- o_ovf_cnt  out  CNT_W  saturating count of results with overflow set.

## Operation
- Storage: DEPTH entries of {overflow, data}, circular write/read pointers of log2(DEPTH) bits plus separate occupancy counter; pointers wrap DEPTH-1 -> 0.
- push = i_valid && (!full || pop); pop = o_valid && i_ready.
- Push writes {i_overflow, i_data} at write pointer, increments it. Pop increments read pointer. Occupancy: +1 push only, -1 pop only, unchanged on both or neither.
- Full and simultaneous pop: push accepted into freed slot; no drop; o_count stays DEPTH.
- Empty: i_ready ignored; push on empty makes entry visible next cycle (no fall-through in same cycle).
- Drop: i_valid && full && !pop -> result discarded, o_drop high for the following cycle, pointers unchanged.
- o_data/o_overflow driven from read-pointer entry; held stable while o_valid && !i_ready. When o_valid is low, o_data/o_overflow hold last head contents (don't-care to consumer; bench must not check).
- Overflow counter: increments on every i_valid with i_overflow=1, whether pushed or dropped; saturates at 2^CNT_W-1 (no wrap). i_clr_cnt forces 0; clear wins over simultaneous increment.
- No state machine beyond FIFO control; block is a pure buffer with status.

## Timing
- Reset (i_rst high at edge): o_valid=0, o_data=0, o_overflow=0, o_full=0, o_count=0, o_drop=0, o_ovf_cnt=0, pointers=0; stored entries not cleared (unreadable while empty).
- Reset mid-operation discards all buffered entries; input with i_valid on the reset edge is not captured and not counted.
- Latency: i_valid sampled at edge N -> o_valid/o_data valid after edge N (one cycle). Back-to-back i_valid every cycle sustained with i_ready held high: throughput 1 result/cycle, occupancy 1.
- Handshake: transfer completes on edge where o_valid && i_ready; next entry (if any) appears after that edge. o_valid never deasserts without a pop or reset.
- All outputs registered or decoded from registered state only; no combinational path from i_valid/i_data/i_ready to any output.
- o_full, o_count update after the same edge as the push/pop causing them.

## Test plan
- Reset then single result: i_valid=1, i_data=12'h7FF, i_overflow=0, i_ready=0 -> next cycle o_valid=1, o_data=12'h7FF, o_count=1; held until i_ready=1, then o_valid=0, o_count=0.
- Fill and drop (DEPTH=4): 5 consecutive results 1..5, i_ready=0 -> o_full=1, o_count=4, o_drop pulses once the cycle after result 5; draining yields 1,2,3,4 in order.
- Full with simultaneous pop: buffer holds 1..4, i_valid with 9 and i_ready=1 same cycle -> no o_drop, o_count=4, drained order 2,3,4,9; pointer wrap exercised.
- Overflow counting: 3 results with i_overflow=1 (one while full and dropped) -> o_ovf_cnt=3; o_overflow=1 on the two buffered heads; CNT_W=2 variant with 5 overflows -> saturates at 3; i_clr_cnt with simultaneous overflow input -> 0.
- Streaming: 20 results on consecutive cycles, i_ready=1 always -> outputs match inputs one cycle later, o_count=1 throughout, no drops.
- Reset mid-operation: 3 entries buffered, i_rst high one cycle with i_valid=1 -> all outputs 0 next cycle; that input not delivered, o_ovf_cnt=0.
